// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The adder is the slave; the producer/consumer side is the master.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_c;

  modport master (
    output in_valid, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_sum, out_c
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_sum, out_c
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder bit per clock, LSB first.
// Result {out_c,out_sum} = in_a + in_b + in_c, ready WIDTH+1 cycles after acceptance.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic             r_inReady;
  logic             r_outValid;

  logic             w_s;
  logic             w_cNext;
  logic             w_lastBit;
  logic             w_inFire;
  logic [WIDTH-1:0] w_sumNext;

  assign w_s       = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_cNext   = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_lastBit = (r_count == CW'(WIDTH - 1));
  assign w_inFire  = bus.in_valid & r_inReady;

  // New sum bit enters at the MSB so the first bit computed ends up at bit 0.
  generate
    if (WIDTH == 1) begin : g_sumOne
      assign w_sumNext = w_s;
    end else begin : g_sumWide
      assign w_sumNext = {w_s, r_sum[WIDTH-1:1]};
    end
  endgenerate

  // The sum register and carry flop double as the result holders, so they
  // stay stable through DONE and IDLE until the next acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_count    <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_inFire) begin
            r_a       <= bus.in_a;
            r_b       <= bus.in_b;
            r_carry   <= bus.in_c;
            r_count   <= '0;
            r_inReady <= 1'b0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_sum   <= w_sumNext;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_cNext;
          r_count <= r_count + CW'(1);
          if (w_lastBit) begin
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  // Ready is masked by reset so nothing is offered acceptance while rst is high.
  assign bus.in_ready  = r_inReady & ~rst;
  assign bus.out_valid = r_outValid;
  assign bus.out_sum   = r_sum;
  assign bus.out_c     = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder at WIDTH=8 with hand-computed sums.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offer an operand set in the current (post-negedge) cycle.
  task automatic startOp(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_c     = c;
    #1;
    checkOutput({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  // Count cycles from the offer cycle until out_valid; scramble inputs meanwhile.
  task automatic waitResult(input logic [7:0] expSum, input logic expC, input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.in_valid = 1'b1;
        bus.in_a     = ~bus.in_a;
        bus.in_b     = 8'h5C;
        bus.in_c     = ~bus.in_c;
      end
      if (n == 8) checkOutput({tag, " early_valid"}, 64'(bus.out_valid), 64'd0);
    end while (!bus.out_valid && n < 30);
    bus.in_valid = 1'b0;
    checkOutput({tag, " latency"}, 64'(n), 64'd9);
    checkOutput({tag, " sum"}, 64'(bus.out_sum), 64'(expSum));
    checkOutput({tag, " carry"}, 64'(bus.out_c), 64'(expC));
    checkOutput({tag, " ready_in_done"}, 64'(bus.in_ready), 64'd0);
  endtask

  task automatic finishOp(input logic [7:0] expSum, input logic expC, input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput({tag, " valid_drop"}, 64'(bus.out_valid), 64'd0);
    checkOutput({tag, " ready_idle"}, 64'(bus.in_ready), 64'd1);
    checkOutput({tag, " hold_sum"}, 64'(bus.out_sum), 64'(expSum));
    checkOutput({tag, " hold_carry"}, 64'(bus.out_c), 64'(expC));
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c,
                               input logic [7:0] expSum, input logic expC, input string tag);
    startOp(a, b, c, tag);
    waitResult(expSum, expC, tag);
    finishOp(expSum, expC, tag);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_c      = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst ready", 64'(bus.in_ready), 64'd0);
    checkOutput("rst valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst sum", 64'(bus.out_sum), 64'd0);
    checkOutput("rst carry", 64'(bus.out_c), 64'd0);
    rst = 1'b0;

    applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
    applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_01");
    applyStimulus(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "a5_5a_c1");
    applyStimulus(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, "a5_5a_c0");

    // Consumer stalls while a producer keeps offering new operands.
    startOp(8'h3C, 8'h0F, 1'b0, "stall");
    waitResult(8'h4B, 1'b0, "stall");
    bus.in_valid = 1'b1;
    bus.in_a     = 8'h11;
    bus.in_b     = 8'h22;
    bus.in_c     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("stall valid", 64'(bus.out_valid), 64'd1);
      checkOutput("stall sum", 64'(bus.out_sum), 64'h4B);
      checkOutput("stall carry", 64'(bus.out_c), 64'd0);
      checkOutput("stall ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput("stall post_hs valid", 64'(bus.out_valid), 64'd0);
    checkOutput("stall post_hs ready", 64'(bus.in_ready), 64'd1);
    checkOutput("stall post_hs sum", 64'(bus.out_sum), 64'h4B);
    waitResult(8'h33, 1'b0, "after_stall");
    finishOp(8'h33, 1'b0, "after_stall");

    // Reset three cycles into RUN, then accept immediately afterwards.
    startOp(8'h55, 8'h66, 1'b1, "abort");
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort ready_in_rst", 64'(bus.in_ready), 64'd0);
    checkOutput("abort valid", 64'(bus.out_valid), 64'd0);
    checkOutput("abort sum", 64'(bus.out_sum), 64'd0);
    checkOutput("abort carry", 64'(bus.out_c), 64'd0);
    rst = 1'b0;
    applyStimulus(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, "post_rst");

    // Full carry chain followed by a carry-free sum.
    applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ff_ff_c1");
    applyStimulus(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "no_leak");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
